garo_trng_ctrl: RTL and testbench
=================================

// Module: garo_trng_ctrl
// PURPOSE
//  Sequences the GARO entropy source and turns its synchronized raw bit stream into WORD_W-bit random words.
//  Steps: warm-up discard, periodic sampling, optional Von Neumann debiasing, repetition-count health test,
//  word assembly. Sits between the GARO (raw_bit = its 2-flop-synchronized output) and a consumer using a valid/ready port.
// PARAMETERS
//  WORD_W      32   bits per delivered word (>=2)
//  SAMPLE_DIV  4    raw_bit sampled once every SAMPLE_DIV clocks (>=1)
//  WARMUP_CYC  256  clocks discarded after enable before collection (>=1)
//  REP_LIMIT   32   run of identical consecutive samples that declares a fault (>=2)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous reset, active-low
//  enable     in   1       1 = run the source; 0 = return to IDLE
//  raw_bit    in   1       synchronized GARO output
//  rnd_ready  in   1       consumer accepts rnd_data
//  rnd_valid  out  1       rnd_data holds a complete word
//  rnd_data   out  WORD_W  random word, stable while rnd_valid=1
//  busy       out  1       1 in WARMUP or COLLECT
//  fault      out  1       health test failed; sticky until fault_clr
//  fault_clr  in   1       clears FAULT
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE, rnd_valid=0, rnd_data=0, busy=0, fault=0; all counters and shift register cleared.
//  States: IDLE, WARMUP, COLLECT, READY, FAULT. busy is registered from state.
//  IDLE -> WARMUP when enable=1. WARMUP: count WARMUP_CYC clocks, then -> COLLECT. enable=0 -> IDLE.
//  COLLECT entry clears the divider, bit count, shift register, run counter and pair latch.
//  Sampling: divider counts 0..SAMPLE_DIV-1. Strobe when divider==SAMPLE_DIV-1 (COLLECT only).
//  Each strobe samples raw_bit. An accepted bit enters shift reg: sr <= {sr[WORD_W-2:0], bit}.
//  Health: run counter = length of the current run of identical samples; reset to 1 on a differing sample.
//   A run reaching REP_LIMIT -> FAULT on the next clock.
//  Word done: the strobe accepting the WORD_W-th bit loads rnd_data; rnd_valid=1 and state=READY next clock.
//  First-word latency, no debias: rnd_valid rises 1+WARMUP_CYC+WORD_W*SAMPLE_DIV clocks after the edge that samples enable=1.
//   Defaults: 385 clocks.
//  READY: rnd_data/rnd_valid held until the rnd_valid&rnd_ready edge. rnd_valid=0 on the following clock.
//   After the handshake: enable=1 -> COLLECT (no re-warm-up); enable=0 -> IDLE.
//   enable=0 while READY does not drop the word.
//  enable=0 in COLLECT: -> IDLE next clock, partial word discarded.
//  FAULT: rnd_valid=0, rnd_data=0, busy=0, fault=1. Any pending word is discarded.
//   fault_clr=1 -> IDLE, fault=0 next clock. fault_clr is ignored outside FAULT.
//  Simultaneous events:
//   - Fault trigger on the same strobe that completes a word -> FAULT wins, word dropped.
//   - reset=0 overrides everything, including mid-word and FAULT.
// CONFIGURATION
//  TRNG_VN_DEBIAS_EN defined: strobed samples are taken in pairs (first, second).
//   Pair 10 emits 1, pair 01 emits 0; pairs 00/11 emit nothing. Only emitted bits count toward WORD_W.
//   Health test still sees every raw sample. The pair latch is cleared on COLLECT entry.
//  Not defined: every strobed sample is accepted directly; no pair logic is synthesized.
// TESTING
//  1 Reset: reset=0 for 3 clk, toggle raw_bit -> rnd_valid=0, rnd_data=0, busy=0, fault=0 throughout.
//  2 No debias, defaults, raw_bit alternating 1,0 per strobe, rnd_ready=1, enable=1
//     -> rnd_valid at clock 385, rnd_data=32'hAAAAAAAA (first sample 1), valid for exactly one clock.
//  3 raw_bit held 1 in COLLECT -> fault=1 on the clock after the 32nd strobe;
//     rnd_valid never rises; fault_clr pulse -> IDLE, fault=0.
//  4 Backpressure: rnd_ready=0 for 50 clocks after valid -> rnd_data stable and rnd_valid=1 for all 50;
//     rnd_ready=1 -> one transfer, then COLLECT.
//  5 enable=0 midway through COLLECT (16 bits in) -> IDLE next clock.
//     Re-enable -> full WARMUP again, word contains no stale bits.
//  6 TRNG_VN_DEBIAS_EN, samples 1,0,1,1,0,1 repeating -> emits 1,0 per 6 samples;
//     first word 32'hAAAAAAAA after 96 strobes.

Source files
------------

// File: rtl/garo_trng_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : garo_trng_ctrl
// Purpose  : Sequences the GARO entropy source: warm-up discard, periodic
//            sampling, optional Von Neumann debiasing (TRNG_VN_DEBIAS_EN),
//            repetition-count health test and word assembly (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module garo_trng_ctrl #(
    parameter int WORD_W     = 32,
    parameter int SAMPLE_DIV = 4,
    parameter int WARMUP_CYC = 256,
    parameter int REP_LIMIT  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              raw_bit,
    input  logic              rnd_ready,
    output logic              rnd_valid,
    output logic [WORD_W-1:0] rnd_data,
    output logic              busy,
    output logic              fault,
    input  logic              fault_clr
);

    localparam int c_DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_WARM_W = $clog2(WARMUP_CYC + 1);
    localparam int c_BIT_W  = $clog2(WORD_W);
    localparam int c_RUN_W  = $clog2(REP_LIMIT + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [c_WARM_W-1:0] c_WARM_END  = c_WARM_W'(WARMUP_CYC);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WORD_W - 1);
    localparam logic [c_RUN_W-1:0]  c_RUN_LIMIT = c_RUN_W'(REP_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_READY   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_busy;
    logic                r_fault;
    logic                r_valid;
    logic [WORD_W-1:0]   r_data;

    logic [c_WARM_W-1:0] r_warm_cnt;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0]   r_sr;
    logic [c_RUN_W-1:0]  r_run;
    logic                r_last;

    logic                w_strobe;
    logic                w_accept;
    logic                w_accept_bit;
    logic [c_RUN_W-1:0]  w_run_next;
    logic                w_rep_fail;
    logic                w_word_done;
    logic                w_enter_collect;
    logic [WORD_W-1:0]   w_sr_next;

    assign w_strobe    = (r_state == ST_COLLECT) && (r_div == c_DIV_LAST);
    assign w_sr_next   = {r_sr[WORD_W-2:0], w_accept_bit};
    assign w_word_done = w_accept && (r_bit_cnt == c_BIT_LAST);
    assign w_rep_fail  = w_strobe && (w_run_next == c_RUN_LIMIT);

    // A run restarts at 1 on the first sample after entry or on any change.
    always_comb begin
        w_run_next = c_RUN_W'(1);
        if ((r_run != '0) && (raw_bit == r_last)) begin
            w_run_next = r_run + c_RUN_W'(1);
        end
    end

`ifdef TRNG_VN_DEBIAS_EN
    logic r_pair_have;
    logic r_pair_first;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pair_have  <= 1'b0;
            r_pair_first <= 1'b0;
        end else if (w_enter_collect) begin
            r_pair_have  <= 1'b0;
            r_pair_first <= 1'b0;
        end else if (w_strobe) begin
            r_pair_have <= ~r_pair_have;
            if (!r_pair_have) begin
                r_pair_first <= raw_bit;
            end
        end
    end

    // Pair 10 emits 1, pair 01 emits 0: the emitted bit is the first sample.
    assign w_accept     = w_strobe && r_pair_have && (r_pair_first != raw_bit);
    assign w_accept_bit = r_pair_first;
`else
    assign w_accept     = w_strobe;
    assign w_accept_bit = raw_bit;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_next = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!enable)                       w_state_next = ST_IDLE;
                else if (r_warm_cnt == c_WARM_END) w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                // Health failure outranks a word completing on the same strobe.
                if (!enable)          w_state_next = ST_IDLE;
                else if (w_rep_fail)  w_state_next = ST_FAULT;
                else if (w_word_done) w_state_next = ST_READY;
            end
            ST_READY: begin
                if (rnd_ready) w_state_next = enable ? ST_COLLECT : ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_collect = (w_state_next == ST_COLLECT) && (r_state != ST_COLLECT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_WARMUP) || (w_state_next == ST_COLLECT);
            r_fault <= (w_state_next == ST_FAULT);
            r_valid <= (w_state_next == ST_READY);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_warm_cnt <= '0;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_sr       <= '0;
            r_run      <= '0;
            r_last     <= 1'b0;
            r_data     <= '0;
        end else begin
            if ((r_state == ST_WARMUP) && (w_state_next == ST_WARMUP)) begin
                r_warm_cnt <= r_warm_cnt + c_WARM_W'(1);
            end else begin
                r_warm_cnt <= '0;
            end

            if (w_enter_collect) begin
                r_div     <= '0;
                r_bit_cnt <= '0;
                r_sr      <= '0;
                r_run     <= '0;
                r_last    <= 1'b0;
            end else if (r_state == ST_COLLECT) begin
                r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_W'(1);
                if (w_strobe) begin
                    r_run  <= w_run_next;
                    r_last <= raw_bit;
                end
                if (w_accept) begin
                    r_sr      <= w_sr_next;
                    r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + c_BIT_W'(1);
                end
            end

            if (w_state_next == ST_FAULT) begin
                r_data <= '0;
            end else if (w_word_done && (w_state_next == ST_READY)) begin
                r_data <= w_sr_next;
            end
        end
    end

    assign rnd_valid = r_valid;
    assign rnd_data  = r_data;
    assign busy      = r_busy;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_garo_trng_ctrl.sv
`default_nettype none
// tb_garo_trng_ctrl: directed bench for garo_trng_ctrl at default parameters.
// Raw samples are driven on a schedule anchored to the enable edge.
module tb_garo_trng_ctrl;

    localparam int WARMUP = 256;
    localparam int DIV    = 4;
    localparam int REP    = 32;
`ifdef TRNG_VN_DEBIAS_EN
    localparam int NSTROBE = 96;
`else
    localparam int NSTROBE = 32;
`endif
    localparam int RAW_START = WARMUP + 2;
    localparam int LAT       = 1 + WARMUP + NSTROBE * DIV;
    localparam int FAULT_LAT = 1 + WARMUP + REP * DIV;
    localparam logic [31:0] WORD_EXP = 32'hAAAAAAAA;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic        raw_bit   = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        fault_clr = 1'b0;
    logic        rnd_valid;
    logic [31:0] rnd_data;
    logic        busy;
    logic        fault;

    int vectors     = 0;
    int miscompares = 0;
    int fv;
    int ff;

    always #5 clk = ~clk;

    garo_trng_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .raw_bit   (raw_bit),
        .rnd_ready (rnd_ready),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .busy      (busy),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic pattern_bit(input int idx);
`ifdef TRNG_VN_DEBIAS_EN
        case (idx % 6)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return 1'b1;
            4:       return 1'b0;
            default: return 1'b1;
        endcase
`else
        return (idx % 2 == 0);
`endif
    endfunction

    // Call at the negedge where enable was just raised; m counts edges after it.
    task automatic drive_cycles(input int n_cyc, input bit hold_one, input bit stop_valid,
                                input bit stop_fault, output int first_valid, output int first_fault);
        int edge_n;
        first_valid = -1;
        first_fault = -1;
        for (int m = 0; m < n_cyc; m++) begin
            @(negedge clk);
            if (rnd_valid === 1'b1 && first_valid < 0) first_valid = m;
            if (fault === 1'b1 && first_fault < 0) first_fault = m;
            if ((stop_valid && first_valid >= 0) || (stop_fault && first_fault >= 0)) break;
            edge_n = m + 1;
            if (hold_one)                 raw_bit = 1'b1;
            else if (edge_n >= RAW_START) raw_bit = pattern_bit((edge_n - RAW_START) / DIV);
            else                          raw_bit = edge_n[0];
        end
    endtask

    initial begin
        // 1: reset holds every output low even with enable and a toggling raw_bit
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            raw_bit = ~raw_bit;
            chk("t1_valid", 32'(rnd_valid), 32'd0);
            chk("t1_data",  rnd_data,       32'd0);
            chk("t1_busy",  32'(busy),      32'd0);
            chk("t1_fault", 32'(fault),     32'd0);
        end
        enable = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("t1_idle_busy",  32'(busy),  32'd0);
        chk("t1_clr_ignored", 32'(fault), 32'd0);

        // 2: first word latency and content, one-clock valid with ready=1
        rnd_ready = 1'b1;
        enable    = 1'b1;
        drive_cycles(LAT + 20, 1'b0, 1'b1, 1'b0, fv, ff);
        chk("t2_latency", 32'(fv), 32'(LAT));
        chk("t2_data",    rnd_data, WORD_EXP);
        chk("t2_busy_rdy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t2_valid_drop",   32'(rnd_valid), 32'd0);
        chk("t2_busy_collect", 32'(busy),      32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("t2_busy_idle", 32'(busy), 32'd0);

        // 3: stuck-at-1 source trips the repetition test; FAULT beats word completion
        enable = 1'b1;
        drive_cycles(FAULT_LAT + 20, 1'b1, 1'b0, 1'b1, fv, ff);
        chk("t3_fault_time",  32'(ff), 32'(FAULT_LAT));
        chk("t3_no_valid",    32'(fv), 32'hFFFFFFFF);
        chk("t3_busy",        32'(busy), 32'd0);
        chk("t3_data_zero",   rnd_data, 32'd0);
        @(negedge clk);
        chk("t3_fault_sticky", 32'(fault), 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        enable    = 1'b0;
        chk("t3_fault_clr", 32'(fault), 32'd0);
        chk("t3_busy_idle", 32'(busy),  32'd0);
        @(negedge clk);
        chk("t3_still_idle", 32'(busy), 32'd0);

        // 4: 50 clocks of backpressure, then one transfer and back to COLLECT
        rnd_ready = 1'b0;
        enable    = 1'b1;
        drive_cycles(LAT + 20, 1'b0, 1'b1, 1'b0, fv, ff);
        chk("t4_latency", 32'(fv), 32'(LAT));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(rnd_valid), 32'd1);
            chk("t4_hold_data",  rnd_data,       WORD_EXP);
        end
        rnd_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid_drop", 32'(rnd_valid), 32'd0);
        chk("t4_collect",    32'(busy),      32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("t4_idle", 32'(busy), 32'd0);

        // 5: enable drop halfway through a word, then full re-warm-up
        enable = 1'b1;
        drive_cycles(WARMUP + 1 + (NSTROBE / 2) * DIV + 1, 1'b0, 1'b0, 1'b0, fv, ff);
        chk("t5_no_word_yet", 32'(fv), 32'hFFFFFFFF);
        chk("t5_busy_mid",    32'(busy), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("t5_idle_busy",  32'(busy),      32'd0);
        chk("t5_idle_valid", 32'(rnd_valid), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        drive_cycles(LAT + 20, 1'b0, 1'b1, 1'b0, fv, ff);
        chk("t5_relatency", 32'(fv), 32'(LAT));
        chk("t5_redata",    rnd_data, WORD_EXP);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);

        // 6: enable dropped while READY keeps the word; handshake then goes IDLE
        rnd_ready = 1'b0;
        enable    = 1'b1;
        drive_cycles(LAT + 20, 1'b0, 1'b1, 1'b0, fv, ff);
        chk("t6_latency", 32'(fv), 32'(LAT));
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_hold_valid", 32'(rnd_valid), 32'd1);
            chk("t6_hold_data",  rnd_data,       WORD_EXP);
        end
        rnd_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid_drop", 32'(rnd_valid), 32'd0);
        chk("t6_idle",       32'(busy),      32'd0);

        // 7: reset during COLLECT clears everything
        enable = 1'b1;
        drive_cycles(WARMUP + 20, 1'b0, 1'b0, 1'b0, fv, ff);
        reset = 1'b0;
        @(negedge clk);
        chk("t7_busy",  32'(busy),  32'd0);
        chk("t7_data",  rnd_data,   32'd0);
        chk("t7_fault", 32'(fault), 32'd0);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
